// File: rtl/btn_pulse_multi.sv
// Multi-channel button conditioner: shared sample-tick divider, then per channel a
// synchronizer, tick-sampled debouncer and a press/hold/auto-repeat FSM.
module btn_pulse_multi #(
    parameter int N_CH         = 5,
    parameter int DIV          = 500000,
    parameter int STABLE_CNT   = 4,
    parameter int HOLD_TICKS   = 200,
    parameter int REPEAT_TICKS = 40,
    parameter int REPEAT_EN    = 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [N_CH-1:0] btn,
    output logic            tick,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    localparam int DIV_W    = $clog2(DIV);
    localparam int STAB_W   = $clog2(STABLE_CNT + 1);
    localparam int HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE    = DIV_W'(1);
    localparam logic [STAB_W-1:0] STAB_LIM   = STAB_W'(STABLE_CNT);
    localparam logic [STAB_W-1:0] STAB_ONE   = STAB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LIM   = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] REPEAT_LIM = HOLD_W'(REPEAT_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_e;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [N_CH-1:0]  sync1_q, sync2_q;

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_ONE;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_cnt_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
        end
    end

    // Tick is decoded from the counter so it is low whenever the counter is in reset.
    assign tick = (div_cnt_q == DIV_LAST);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic              s;
        logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              release_q, release_d;
        logic              long_q, long_d;
        logic              repeat_q, repeat_d;
        logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
        state_e            state_q, state_d;

        assign s = sync2_q[i];

        always_comb begin
            stab_cnt_d = stab_cnt_q;
            level_d    = level_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            if (tick) begin
                if (s != level_q) begin
                    if ((stab_cnt_q + STAB_ONE) == STAB_LIM) begin
                        level_d    = ~level_q;
                        stab_cnt_d = '0;
                        press_d    = ~level_q;
                        release_d  = level_q;
                    end else begin
                        stab_cnt_d = stab_cnt_q + STAB_ONE;
                    end
                end else begin
                    stab_cnt_d = '0;
                end
            end
        end

        // A release accepted on this edge wins over any long/repeat event due now.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            long_d     = 1'b0;
            repeat_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    hold_cnt_d = '0;
                    if (press_d) begin
                        state_d = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (release_d) begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = '0;
                    end else if (tick) begin
                        if ((hold_cnt_q + HOLD_ONE) == HOLD_LIM) begin
                            long_d     = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = ST_HELD;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_ONE;
                        end
                    end
                end
                ST_HELD: begin
                    if (release_d) begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = '0;
                    end else if (tick && (REPEAT_EN != 0)) begin
                        if ((hold_cnt_q + HOLD_ONE) == REPEAT_LIM) begin
                            repeat_d   = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_ONE;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                stab_cnt_q <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
                repeat_q   <= 1'b0;
                hold_cnt_q <= '0;
                state_q    <= ST_IDLE;
            end else begin
                stab_cnt_q <= stab_cnt_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
                long_q     <= long_d;
                repeat_q   <= repeat_d;
                hold_cnt_q <= hold_cnt_d;
                state_q    <= state_d;
            end
        end

        assign level[i]         = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
        assign repeat_pulse[i]  = repeat_q;
    end

endmodule

// File: doc/btn_pulse_multi.md
BTN_PULSE_MULTI -- requirements
Module: btn_pulse_multi

Interface
REQ-001 The block SHALL have parameter N_CH, default 5, meaning number of independent button channels (>=1).
REQ-002 The block SHALL have parameter DIV, default 500000, meaning clock cycles per sample tick (>=2).
REQ-003 The block SHALL have parameter STABLE_CNT, default 4, meaning consecutive differing samples required to accept a level change (>=1).
REQ-004 The block SHALL have parameter HOLD_TICKS, default 200, meaning sample ticks of continuous press before long_pulse (>=1).
REQ-005 The block SHALL have parameter REPEAT_TICKS, default 40, meaning sample ticks between repeat pulses after long_pulse (>=1).
REQ-006 The block SHALL have parameter REPEAT_EN, default 1, meaning 1 enables auto-repeat and 0 disables it.
REQ-007 The block SHALL have port clock, input, 1, meaning the single system clock, rising edge.
REQ-008 The block SHALL have port resetn, input, 1, meaning asynchronous active-low reset.
REQ-009 The block SHALL have port btn, input, N_CH, meaning raw asynchronous button levels, 1 = pressed.
REQ-010 The block SHALL have port tick, output, 1, meaning one-cycle sample strobe.
REQ-011 The block SHALL have port level, output, N_CH, meaning debounced button level.
REQ-012 The block SHALL have port press_pulse, output, N_CH, meaning one-cycle strobe on accepted press.
REQ-013 The block SHALL have port release_pulse, output, N_CH, meaning one-cycle strobe on accepted release.
REQ-014 The block SHALL have port long_pulse, output, N_CH, meaning one-cycle strobe when a press reaches HOLD_TICKS.
REQ-015 The block SHALL have port repeat_pulse, output, N_CH, meaning one-cycle auto-repeat strobe.

Function
REQ-016 The block SHALL run all logic in the clock domain; no derived clocks and no signal used as a clock.
REQ-017 The tick divider SHALL count 0..DIV-1, wrap to 0, and assert tick for exactly the one cycle in which the count equals DIV-1.
REQ-018 Each btn bit SHALL pass through a two-flop synchronizer (reset value 0); only the second flop output ("s") is used downstream.
REQ-019 Per channel, on a tick cycle with s != level, the stability counter SHALL increment; on a tick cycle with s == level it SHALL clear to 0; on non-tick cycles it SHALL hold.
REQ-020 When the increment would bring the stability counter to STABLE_CNT, level SHALL toggle on that clock edge and the counter SHALL clear to 0.
REQ-021 press_pulse[i] SHALL rise on the same edge as level[i] 0->1 and stay high exactly one cycle; release_pulse[i] likewise for 1->0.
REQ-022 Per channel the FSM SHALL have states IDLE, PRESSED, HELD; IDLE->PRESSED on accepted press, PRESSED/HELD->IDLE on accepted release.
REQ-023 In PRESSED, a hold counter SHALL increment each tick; on the tick it reaches HOLD_TICKS, long_pulse SHALL assert one cycle, the hold counter SHALL clear and the state SHALL go to HELD.
REQ-024 In HELD with REPEAT_EN=1, the hold counter SHALL increment each tick and, on reaching REPEAT_TICKS, assert repeat_pulse one cycle and clear; with REPEAT_EN=0, HELD SHALL emit nothing until release.
REQ-025 Entering IDLE SHALL clear the hold counter; a release on the same edge as a long or repeat event SHALL take priority: release_pulse only, no long/repeat pulse.
REQ-026 Channels SHALL be fully independent; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.
REQ-027 Counter widths SHALL be ceil(log2(max+1)) of their respective limits; no counter SHALL exceed its limit or wrap unintentionally.

Reset
REQ-028 On resetn low, asynchronously: divider count 0, tick 0, synchronizers 0, level 0, all pulse outputs 0, all counters 0, all FSMs IDLE.
REQ-029 After resetn deassertion, a btn held high SHALL be treated as a new press (press_pulse fires after debounce); reset mid-press SHALL abort the press without release_pulse.

Verification
REQ-030 Bench params N_CH=2, DIV=4, STABLE_CNT=3, HOLD_TICKS=5, REPEAT_TICKS=2, REPEAT_EN=1 unless stated.
REQ-031 Clean press on btn[0] held 100 cycles -> tick every 4 cycles; level[0]=1 and one press_pulse[0] within 3 ticks + 3 cycles of the btn edge; no other pulses until long.
REQ-032 Bounce: btn[0] toggles every 5 cycles for 40 cycles then settles high -> no level change during bounce, exactly one press_pulse after settling.
REQ-033 Long hold on btn[1] -> long_pulse[1] 5 ticks after press acceptance, then repeat_pulse[1] every 2 ticks (8 cycles) until release; release -> one release_pulse[1], no further repeats.
REQ-034 REPEAT_EN=0, same hold -> one long_pulse, zero repeat_pulse, one release_pulse.
REQ-035 Reset asserted mid-hold (HELD state) -> all outputs 0 immediately; btn still high after deassertion -> new press_pulse after debounce, no release_pulse.
